// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin subtractor, LSB first, registered borrow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    // full-subtractor cell outputs for the current bit
    logic             diff_bit;
    logic             br_next;

    // single full-subtractor cell on the operand LSBs and the stored borrow
    always_comb begin
        diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    end

    // next-state logic: capture on start, shift one bit per RUN cycle, publish on the last bit
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d  = {diff_bit, res_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // the result register is only copied out here, so partial sums never leak
                    d_d     = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH 8 and 4
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4;
    logic [3:0] d4;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] held8 = '0;
    logic [4:0] held4 = '0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // drive point: just after the falling edge, after the monitors have sampled
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // WIDTH=8 monitor: score results on done, otherwise outputs must hold
    always @(negedge clk) begin
        if (!rst_n) begin
            held8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 1, 0);
            end else begin
                check("result8", {bout8, d8}, q8.pop_front());
            end
            held8 = {bout8, d8};
        end else begin
            check("hold8", {bout8, d8}, held8);
        end
    end

    // WIDTH=4 monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            held4 = '0;
        end else if (done4) begin
            if (q4.size() == 0) begin
                check("unexpected_done4", 1, 0);
            end else begin
                check("result4", {bout4, d4}, q4.pop_front());
            end
            held4 = {bout4, d4};
        end else begin
            check("hold4", {bout4, d4}, held4);
        end
    end

    task automatic wait_done8(input string name);
        for (int i = 0; i < 40 && !done8; i++) step();
        if (!done8) check(name, 0, 1);
    endtask

    task automatic wait_done4(input string name);
        for (int i = 0; i < 20 && !done4; i++) step();
        if (!done4) check(name, 0, 1);
    endtask

    // one 8-bit operation with a single-cycle start; timing is checked as well
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [8:0] exp);
        int t0;
        int busy_n;
        step();
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        q8.push_back(exp);
        t0 = cyc;
        step();
        start8 = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 40 && !done8; i++) begin
            if (busy8) busy_n++;
            step();
        end
        if (!done8) begin
            check("timeout8", 0, 1);
        end else begin
            check("busy_cycles", busy_n, 8);
            check("done_latency", cyc - t0, 9);
            check("busy_low_in_done", busy8, 0);
            step();
            check("done_one_cycle", done8, 0);
        end
    endtask

    initial begin
        int t1, t2;
        logic [4:0] e4;

        // reset state
        step(); step();
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_d8", {bout8, d8}, 0);
        check("rst_busy4", busy4, 0);
        check("rst_d4", {done4, bout4, d4}, 0);
        rst_n = 1'b1;
        step();

        op8(8'd100, 8'd37, 1'b0, 9'h03F);
        op8(8'd5,   8'd10, 1'b0, 9'h1FB);
        op8(8'd0,   8'd0,  1'b1, 9'h1FF);

        // start held high; operands toggled while the first operation runs
        step();
        a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h000);
        step();
        for (int i = 0; i < 40 && !done8; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            step();
        end
        if (!done8) check("timeout_held1", 0, 1);
        t1 = cyc;
        // 60 - 90 - 1 = -31 -> 9'h1E1
        a8 = 8'h3C; b8 = 8'h5A; bin8 = 1'b1;
        q8.push_back(9'h1E1);
        step();
        check("held_no_accept_in_done", {busy8, done8}, 2'b00);
        step();
        check("held_accept_at_idle", busy8, 1);
        start8 = 1'b0;
        wait_done8("timeout_held2");
        t2 = cyc;
        check("done_spacing", t2 - t1, 10);
        step();

        // reset in the middle of an operation: no result is expected
        step();
        a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        check("pre_reset_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_d", d8, 0);
        check("abort_bout", bout8, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("idle_after_abort", {busy8, done8}, 2'b00);
        op8(8'd9, 8'd3, 1'b0, 9'h006);

        // exhaustive WIDTH=4 sweep with start held, next operands set on each done
        step();
        start4 = 1'b1;
        for (int c = 0; c < 512; c++) begin
            logic [3:0] av;
            logic [3:0] bv;
            logic       bi;
            av = 4'(c >> 5);
            bv = 4'(c >> 1);
            bi = 1'(c);
            e4 = 5'((int'(av) - int'(bv) - int'(bi)) & 31);
            a4 = av; b4 = bv; bin4 = bi;
            q4.push_back(e4);
            if (c == 0) step();
            step();
            wait_done4("timeout4");
        end
        start4 = 1'b0;
        step(); step();

        check("q8_drained", q8.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor: it computes d = a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's full-adder cell. It sits in datapaths where area matters more than latency. Operands are captured on a start pulse, and the result is presented with a one-cycle done strobe.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; d and bout valid from this cycle on
- d  output  WIDTH  difference, registered, held until next completion
- bout  output  1  borrow-out, registered, held until next completion

## Operation
- Reset (async, rst_n=0) clears state to IDLE, busy=0, done=0, d=0, bout=0, and all shift registers, bit counter and borrow flop.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE, start=1:
  - load a and b into shift registers and bin into the borrow flop;
  - set the counter to 0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge, with ai and bi the current LSBs and br the borrow flop:
  - diff bit = ai ^ bi ^ br;
  - next br = (~ai & bi) | (~(ai ^ bi) & br);
  - shift the diff bit into the MSB of the internal result register;
  - shift the operand registers right;
  - increment the counter.
- RUN, when the counter reaches WIDTH−1 at an edge:
  - that edge processes the last bit;
  - d and bout are loaded from the final result and final borrow;
  - go to DONE.
- DONE lasts one cycle (done=1), then returns to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- a, b and bin may change freely after capture; they have no effect on the operation in flight.
- d and bout change only on the edge entering DONE. Partial results are never visible.
- Arithmetic:
  - {bout, d} equals the (WIDTH+1)-bit two's-complement result of a − b − bin;
  - bout=1 exactly when a < b + bin (unsigned).

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 from after E0.
- Edges E1..EWIDTH process bits 0..WIDTH−1.
- After EWIDTH: busy=0, done=1, and d and bout are valid.
- After EWIDTH+1: done=0 and the state is IDLE.
- The earliest next acceptance is at EWIDTH+2.
- Throughput is one operation per WIDTH+2 cycles with start held high.
- Reset mid-RUN or in DONE:
  - the operation is aborted immediately, with no done pulse;
  - d and bout go to 0;
  - the next start after rst_n deasserts behaves normally.

## Test plan
- WIDTH=8, a=100, b=37, bin=0, 1-cycle start.
  - Required: busy for 8 cycles; done exactly 9 edges after the start edge; d=8'h3F, bout=0.
- WIDTH=8, a=5, b=10, bin=0.
  - Required: d=8'hFB, bout=1.
- WIDTH=8, a=0, b=0, bin=1.
  - Required: d=8'hFF, bout=1.
- WIDTH=8, a=8'hFF, b=8'hFF, bin=0, with start held high, plus random a, b and bin toggled during RUN.
  - Required for the first operation: d=0, bout=0, unaffected by the toggling.
  - Required with start held: the second operation is accepted only at the IDLE edge, and done pulses are exactly 10 cycles apart.
- Reset in the middle of an operation: a=200, b=1; assert rst_n=0 for one cycle at the 4th RUN edge.
  - Required: busy, done, d and bout all 0 immediately, with no done pulse.
  - Then a=9, b=3 completes with d=6, bout=0.
- WIDTH=4, exhaustive sweep of all a, b, bin (512 cases), back to back.
  - Required: {bout, d} == (a − b − bin) mod 32 for every case; d and bout unchanged between done pulses.
